// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter with bounded bursts in front of a single-ported data memory.
// Optional port-1 atomic hold is compiled in with DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
  parameter int MAX_BURST = 2,
  parameter int DEPTH     = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic        lock1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  localparam int              CW        = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]   BURST_MAX = CW'(MAX_BURST);
  localparam logic [29:0]     DEPTH_W   = 30'(DEPTH);

  logic          last_gnt_q, last_gnt_d;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic          rvalid0_q, rvalid1_q, err_q;
  logic [31:0]   rdata0_q, rdata1_q;

  logic win1;
  logic grant;
  logic sel_we;
  logic in_range;
  logic lock_hold;

`ifdef DMEM_ARB_LOCK_EN
  assign lock_hold = lock1 & last_gnt_q;
`else
  logic unused_lock1;
  assign unused_lock1 = lock1;
  assign lock_hold    = 1'b0;
`endif

  // burst_cnt_q == 0 only right after reset: no burst is running, so the
  // reset value last_gnt_q = 1 hands the first contended grant to port 0.
  always_comb begin
    win1 = req1;
    if (req0 && req1) begin
      if (lock_hold) begin
        win1 = 1'b1;
      end else if (burst_cnt_q != '0 && burst_cnt_q < BURST_MAX) begin
        win1 = last_gnt_q;
      end else begin
        win1 = ~last_gnt_q;
      end
    end
  end

  always_comb begin
    grant     = (req0 | req1) & ~rst;
    gnt0      = grant & ~win1;
    gnt1      = grant & win1;
    mem_addr  = gnt1 ? addr1  : addr0;
    mem_wdata = gnt1 ? wdata1 : wdata0;
    sel_we    = gnt1 ? we1    : we0;
    in_range  = mem_addr[31:2] < DEPTH_W;
    mem_read  = grant & ~sel_we & in_range;
    mem_write = grant & sel_we & in_range;
  end

  always_comb begin
    last_gnt_d  = last_gnt_q;
    burst_cnt_d = burst_cnt_q;
    if (grant) begin
      if (win1 == last_gnt_q) begin
        if (burst_cnt_q != BURST_MAX) begin
          burst_cnt_d = burst_cnt_q + CW'(1);
        end
      end else begin
        last_gnt_d  = win1;
        burst_cnt_d = CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_gnt_q  <= 1'b1;
      burst_cnt_q <= '0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      last_gnt_q  <= last_gnt_d;
      burst_cnt_q <= burst_cnt_d;
      rvalid0_q   <= gnt0 & ~we0;
      rvalid1_q   <= gnt1 & ~we1;
      err_q       <= grant & ~in_range;
      if (gnt0 && !we0) begin
        rdata0_q <= in_range ? mem_rdata : '0;
      end
      if (gnt1 && !we1) begin
        rdata1_q <= in_range ? mem_rdata : '0;
      end
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign err     = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic against a
// history-based arbitration model and a reference word memory.
module tb_dmem_arbiter;

  localparam int MAX_BURST = 2;
  localparam int DEPTH     = 128;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1, lock1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_BURST(MAX_BURST), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock1(lock1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err(err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  // Memory block seen by the DUT (combinational read, write at the edge).
  logic [31:0] tb_mem [DEPTH];
  assign mem_rdata = (mem_addr[31:2] < 30'(DEPTH)) ? tb_mem[mem_addr[8:2]] : 32'hBAD0_BAD0;
  always @(posedge clk) begin
    if (mem_write && mem_addr[31:2] < 30'(DEPTH)) tb_mem[mem_addr[8:2]] <= mem_wdata;
  end

  // Scoreboard / reference model state
  logic [31:0] ref_mem [DEPTH];
  int          hist[$];
  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];
  logic [31:0] hold0, hold1;
  logic        exp_err;
  int          m_win;
  int          obs_win;
  int          checks = 0;
  int          errors = 0;

  int exp3[6] = '{0, 0, 1, 1, 0, 0};
`ifdef DMEM_ARB_LOCK_EN
  localparam int N6 = 4;
  int exp6[N6] = '{1, 1, 1, 1};
`else
  localparam int N6 = 8;
  int exp6[N6] = '{0, 0, 1, 1, 0, 0, 1, 1};
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check at the falling edge, then advance the model across the rising edge.
  task automatic check_cycle();
    int          last, streak, win;
    logic        we, inr;
    logic [31:0] a, d, rd;
    @(negedge clk);
    chk("rvalid0", rvalid0, exp_q0.size() > 0);
    if (exp_q0.size() > 0) hold0 = exp_q0.pop_front();
    chk("rdata0", rdata0, hold0);
    chk("rvalid1", rvalid1, exp_q1.size() > 0);
    if (exp_q1.size() > 0) hold1 = exp_q1.pop_front();
    chk("rdata1", rdata1, hold1);
    chk("err", err, exp_err);

    // A port's streak is its run of most recent consecutive grants.
    last   = (hist.size() > 0) ? hist[$] : 1;
    streak = 0;
    for (int i = hist.size() - 1; i >= 0 && hist[i] == last; i--) streak++;
    win = -1;
    if (!rst) begin
      if (req0 && req1) begin
        win = (streak > 0 && streak < MAX_BURST) ? last : 1 - last;
`ifdef DMEM_ARB_LOCK_EN
        if (lock1 && last == 1) win = 1;
`endif
      end else if (req0) begin
        win = 0;
      end else if (req1) begin
        win = 1;
      end
    end
    a   = (win == 1) ? addr1 : addr0;
    d   = (win == 1) ? wdata1 : wdata0;
    we  = (win == 1) ? we1 : we0;
    inr = (a >> 2) < DEPTH;
    chk("gnt0", gnt0, win == 0);
    chk("gnt1", gnt1, win == 1);
    chk("mem_addr", mem_addr, a);
    chk("mem_wdata", mem_wdata, d);
    chk("mem_read", mem_read, win >= 0 && !we && inr);
    chk("mem_write", mem_write, win >= 0 && we && inr);
    obs_win = gnt1 ? 1 : (gnt0 ? 0 : -1);
    m_win   = win;

    if (rst) begin
      hist.delete();
      exp_q0.delete();
      exp_q1.delete();
      hold0   = '0;
      hold1   = '0;
      exp_err = 1'b0;
    end else begin
      exp_err = (win >= 0) && !inr;
      if (win >= 0) begin
        hist.push_back(win);
        if (hist.size() > 8) void'(hist.pop_front());
        if (we) begin
          if (inr) ref_mem[a[8:2]] = d;
        end else begin
          rd = inr ? ref_mem[a[8:2]] : 32'h0;
          if (win == 0) exp_q0.push_back(rd);
          else exp_q1.push_back(rd);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] idx;
    logic [1:0]  lo;
    idx = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(DEPTH, DEPTH + 64))
                                      : 32'($urandom_range(0, 15));
    lo  = 2'($urandom_range(0, 3));
    return {idx[29:0], lo};
  endfunction

  task automatic new_txn0();
    req0 = 1'b1; we0 = 1'($urandom_range(0, 1)); addr0 = rand_addr(); wdata0 = $urandom();
  endtask

  task automatic new_txn1();
    req1 = 1'b1; we1 = 1'($urandom_range(0, 1)); addr1 = rand_addr(); wdata1 = $urandom();
  endtask

  initial begin
    rst = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      tb_mem[i]  = 32'(i);
      ref_mem[i] = 32'(i);
    end
    hold0 = '0; hold1 = '0; exp_err = 1'b0; m_win = -1; obs_win = -1;
    @(posedge clk);
    #1;

    // Reset holds off contending requesters; port 0 wins first after release.
    req0 = 1; req1 = 1; addr0 = 32'h0; addr1 = 32'h4;
    check_cycle();
    check_cycle();
    rst = 0;
    check_cycle();
    chk("t1_first_gnt", obs_win, 0);
    req0 = 0;
    check_cycle();
    req1 = 0;
    check_cycle();

    // Single read of preloaded word 2.
    req0 = 1; we0 = 0; addr0 = 32'h8;
    check_cycle();
    req0 = 0;
    chk("t2_rvalid0", rvalid0, 1'b1);
    chk("t2_rdata0", rdata0, 32'd2);
    check_cycle();

    // Contended burst pattern from a fresh reset.
    rst = 1;
    check_cycle();
    rst = 0; req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 32'hC; addr1 = 32'h10;
    for (int i = 0; i < 6; i++) begin
      check_cycle();
      chk("t3_order", obs_win, exp3[i]);
    end
    req0 = 0; req1 = 0;
    check_cycle();

    // Write on port 1 then read-back on port 0.
    req1 = 1; we1 = 1; addr1 = 32'h10; wdata1 = 32'hDEAD_BEEF;
    check_cycle();
    req1 = 0; req0 = 1; we0 = 0; addr0 = 32'h10;
    check_cycle();
    req0 = 0;
    chk("t4_rdata0", rdata0, 32'hDEAD_BEEF);
    chk("t4_rvalid1", rvalid1, 1'b0);
    check_cycle();

    // Out-of-range read and write.
    req0 = 1; we0 = 0; addr0 = 32'h200;
    check_cycle();
    chk("t5_err_rd", err, 1'b1);
    chk("t5_rvalid0", rvalid0, 1'b1);
    chk("t5_rdata0", rdata0, 32'h0);
    we0 = 1; wdata0 = 32'h1234_5678;
    check_cycle();
    req0 = 0;
    chk("t5_err_wr", err, 1'b1);
    check_cycle();

    // Port 1 under lock1 against a continuously requesting port 0.
    rst = 1;
    check_cycle();
    rst = 0; lock1 = 1;
    req0 = 1; we0 = 0; addr0 = 32'h0;
    req1 = 1; we1 = 0; addr1 = 32'h20;
    for (int i = 0; i < N6; i++) begin
      check_cycle();
      chk("t6_order", obs_win, exp6[i]);
      if (obs_win == 1) addr1 = addr1 + 32'h4;
    end
    req1 = 0; lock1 = 0;
    check_cycle();
    chk("t6_after", obs_win, 0);
    req0 = 0;
    check_cycle();

    // Random traffic, honouring hold-until-grant on each port.
    for (int c = 0; c < 500; c++) begin
      if (!req0 && $urandom_range(0, 2) != 0) new_txn0();
      if (!req1 && $urandom_range(0, 2) != 0) new_txn1();
      lock1 = ($urandom_range(0, 5) == 0);
      rst   = ($urandom_range(0, 60) == 0);
      check_cycle();
      if (m_win == 0) begin
        if ($urandom_range(0, 1) == 1) new_txn0();
        else req0 = 0;
      end
      if (m_win == 1) begin
        if ($urandom_range(0, 1) == 1) new_txn1();
        else req1 = 0;
      end
    end
    rst = 0; req0 = 0; req1 = 0; lock1 = 0;
    check_cycle();
    check_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
